// File: rtl/mult8_shift_add_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mult8_shift_add_ctrl
// Description : Sequential core of an 8x8 signed shift-add multiplier. It holds
//               the X/A/B registers and drives an external 9-bit adder/subtractor.
// Revision    : 1.0  initial release
// ============================================================================
module mult8_shift_add_ctrl (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Run,
  input  logic       ClearA_LoadB,
  input  logic [7:0] S,
  input  logic [8:0] sum_in,
  output logic [7:0] add_a,
  output logic [7:0] add_b,
  output logic       add_sub,
  output logic [7:0] Aval,
  output logic [7:0] Bval,
  output logic       Xval,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ADD   = 2'd1,
    ST_SHIFT = 2'd2,
    ST_HOLD  = 2'd3
  } state_t;

  localparam logic [2:0] C_LAST_ITER = 3'd7;

  state_t     r_state;
  logic       r_x;
  logic [7:0] r_a;
  logic [7:0] r_b;
  logic [7:0] r_sreg;
  logic [2:0] r_cnt;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state <= ST_IDLE;
      r_x     <= 1'b0;
      r_a     <= 8'd0;
      r_b     <= 8'd0;
      r_sreg  <= 8'd0;
      r_cnt   <= 3'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (Run) begin
            r_x     <= 1'b0;
            r_a     <= 8'd0;
            r_sreg  <= S;
            r_cnt   <= 3'd0;
            r_state <= ST_ADD;
          end else if (ClearA_LoadB) begin
            r_b <= S;
            r_x <= 1'b0;
            r_a <= 8'd0;
          end
        end
        ST_ADD: begin
          if (r_b[0]) begin
            {r_x, r_a} <= sum_in;
          end
          r_state <= ST_SHIFT;
        end
        ST_SHIFT: begin
          // X stays put, which makes this an arithmetic shift of {X,A,B}
          r_a <= {r_x, r_a[7:1]};
          r_b <= {r_a[0], r_b[7:1]};
          if (r_cnt == C_LAST_ITER) begin
            r_state <= ST_HOLD;
          end else begin
            r_cnt   <= r_cnt + 3'd1;
            r_state <= ST_ADD;
          end
        end
        ST_HOLD: begin
          if (ClearA_LoadB) begin
            r_b <= S;
            r_x <= 1'b0;
            r_a <= 8'd0;
          end
          // Waiting for Run to drop keeps a held Run from restarting
          if (!Run) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // All adder operands come from registers, so there is no loop through sum_in
  assign add_a   = r_a;
  assign add_b   = r_sreg;
  assign add_sub = (r_state == ST_ADD) && (r_cnt == C_LAST_ITER);
  assign Aval    = r_a;
  assign Bval    = r_b;
  assign Xval    = r_x;
  assign busy    = (r_state == ST_ADD) || (r_state == ST_SHIFT);
  assign done    = (r_state == ST_HOLD);

endmodule
`default_nettype wire

// File: tb/tb_mult8_shift_add_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mult8_shift_add_ctrl
// Description : Self-checking bench; products compared against signed arithmetic.
// Revision    : 1.0  initial release
// ============================================================================
module tb_mult8_shift_add_ctrl;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       Run = 1'b0;
  logic       ClearA_LoadB = 1'b0;
  logic [7:0] S = 8'd0;
  logic [8:0] sum_in;
  logic [7:0] add_a, add_b, Aval, Bval;
  logic       add_sub, Xval, busy, done;

  int checks = 0;
  int errors = 0;
  logic [7:0] model_b = 8'd0;

  mult8_shift_add_ctrl dut (
    .Clk(Clk), .Reset(Reset), .Run(Run), .ClearA_LoadB(ClearA_LoadB), .S(S),
    .sum_in(sum_in), .add_a(add_a), .add_b(add_b), .add_sub(add_sub),
    .Aval(Aval), .Bval(Bval), .Xval(Xval), .busy(busy), .done(done)
  );

  // External 9-bit adder/subtractor on sign-extended operands
  assign sum_in = add_sub ? ({add_a[7], add_a} - {add_b[7], add_b})
                          : ({add_a[7], add_a} + {add_b[7], add_b});

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic load_b(input logic [7:0] v);
    ClearA_LoadB = 1'b1;
    S = v;
    tick();
    ClearA_LoadB = 1'b0;
    model_b = v;
    check("load_B", {24'd0, Bval}, {24'd0, v});
    check("load_XA", {23'd0, Xval, Aval}, 32'd0);
  endtask

  task automatic run_op(input logic [7:0] s, input bit disturb);
    logic signed [15:0] prod;
    int n, adds, add_pos;
    prod = $signed(model_b) * $signed(s);
    Run = 1'b1;
    S = s;
    ClearA_LoadB = 1'b0;
    tick();
    Run = 1'b0;
    check("start_busy", {30'd0, busy, done}, 32'd2);
    n = 0; adds = 0; add_pos = -1;
    while (!done && n < 40) begin
      if (add_sub) begin
        adds++;
        add_pos = n;
      end
      if (busy && done) check("busy_and_done", 32'd1, 32'd0);
      if (disturb) begin
        S = 8'($urandom);
        ClearA_LoadB = 1'($urandom);
      end
      tick();
      n++;
    end
    ClearA_LoadB = 1'b0;
    Run = 1'b1;
    check("latency", n, 16);
    check("add_sub_count", adds, 1);
    check("add_sub_pos", add_pos, 14);
    check("product", {15'd0, Xval, Aval, Bval}, {15'd0, prod[15], prod});
    check("done_flags", {30'd0, busy, done}, 32'd1);
    // Held Run must keep done and freeze the result
    repeat (3) tick();
    check("hold_done", {30'd0, busy, done}, 32'd1);
    check("hold_product", {15'd0, Xval, Aval, Bval}, {15'd0, prod[15], prod});
    Run = 1'b0;
    tick();
    check("back_idle", {30'd0, busy, done}, 32'd0);
    model_b = prod[7:0];
  endtask

  initial begin
    #2;
    check("reset_state", {add_a, add_b, Aval, Bval[6:0], Xval, add_sub, busy, done},
          32'd0);
    tick();
    Reset = 1'b0;
    tick();
    check("reset_B", {24'd0, Bval}, 32'd0);

    // Directed cases
    load_b(8'h07);
    run_op(8'hFD, 1'b0);        // 7 * -3 = -21
    run_op(8'hFD, 1'b0);        // -21 * -3 = 63
    load_b(8'h80);
    run_op(8'h80, 1'b0);        // -128 * -128
    load_b(8'hFF);
    run_op(8'h01, 1'b0);
    load_b(8'h00);
    run_op(8'h5A, 1'b0);
    load_b(8'h7F);
    run_op(8'h80, 1'b1);        // inputs toggled while busy

    // Reset mid-operation
    Run = 1'b1;
    S = 8'h33;
    tick();
    Run = 1'b0;
    repeat (4) tick();
    #2 Reset = 1'b1;
    #1;
    check("mid_reset", {add_a, add_b, Aval, Bval[6:0], Xval, add_sub, busy, done},
          32'd0);
    check("mid_reset_B", {24'd0, Bval}, 32'd0);
    tick();
    Reset = 1'b0;
    model_b = 8'd0;
    tick();
    check("after_reset_idle", {30'd0, busy, done}, 32'd0);

    // Random operations, sometimes chaining without a reload
    for (int i = 0; i < 12; i++) begin
      if ($urandom_range(0, 2) != 0) load_b(8'($urandom));
      run_op(8'($urandom), 1'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
